n8877_secbuf: RTL

Sector prefetch buffer between the FDC emulator's media read port (faddr/frd/frdata) and the external image memory (SDRAM/flash bridge with a req/ack word interface). The FDC samples frdata one clock after faddr settles and has no stall input, so this block holds one full 256-byte sector in a 128x16 buffer. It refills that buffer from image memory whenever the sector base faddr[19:8] changes. Reads that arrive before the fill completes return FILL data and are flagged.

---
 rtl/n8877_secbuf_pkg.sv | 24 ++
 rtl/n8877_secbuf_ram.sv | 30 +++
 rtl/n8877_secbuf.sv | 121 ++++++++++++
 3 files changed

// File: rtl/n8877_secbuf_pkg.sv
// ============================================================================
// n8877_secbuf_pkg -- sector geometry, FSM encoding and fill pattern
// Revision 1.0
// ============================================================================
`default_nettype none

package n8877_secbuf_pkg;

  localparam int SEC_WORDS = 128;
  localparam int SEC_IDXW  = 7;
  localparam int TAGW      = 12;

  localparam logic [15:0] FILL_WORD = 16'he5e5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/n8877_secbuf_ram.sv
// ============================================================================
// n8877_secbuf_ram -- 128x16 simple dual-port RAM, registered read-old-data
// Revision 1.0
// ============================================================================
`default_nettype none

module n8877_secbuf_ram
  import n8877_secbuf_pkg::*;
(
  input  logic                clk,
  input  logic                we,
  input  logic [SEC_IDXW-1:0] waddr,
  input  logic [15:0]         wdata,
  input  logic [SEC_IDXW-1:0] raddr,
  output logic [15:0]         rdata
);

  logic [15:0] mem [SEC_WORDS];

  // Both assignments are non-blocking, so a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/n8877_secbuf.sv
// ============================================================================
// n8877_secbuf -- one-sector prefetch buffer between FDC media port and image memory
// Revision 1.0
// ============================================================================
`default_nettype none

module n8877_secbuf
  import n8877_secbuf_pkg::*;
#(
  parameter int             MAW      = 24,
  parameter logic [MAW-1:0] IMG_BASE = '0,
  parameter logic [15:0]    FILL     = FILL_WORD
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [19:0]    faddr,
  input  logic           frd,
  output logic [15:0]    frdata,
  output logic [MAW-1:0] mem_addr,
  output logic           mem_req,
  input  logic           mem_ack,
  input  logic [15:0]    mem_rdata,
  output logic           buf_valid,
  output logic           fill_busy,
  output logic           rd_miss
);

  state_t              state;
  logic [TAGW-1:0]     tag;
  logic                tag_valid;
  logic [TAGW-1:0]     fill_tag;
  logic [SEC_IDXW-1:0] idx;
  logic                frd_d;
  logic [15:0]         ram_q;

  logic                tag_hit;
  logic                ram_we;
  logic [MAW-1:0]      word_addr;
  logic                unused_lsb;

  assign tag_hit    = tag_valid && (tag == faddr[19:8]);
  assign ram_we     = (state == ST_WAIT) && mem_ack;
  assign word_addr  = IMG_BASE + MAW'({fill_tag, {SEC_IDXW{1'b0}}}) + MAW'(idx);
  assign fill_busy  = (state != ST_IDLE);
  assign unused_lsb = faddr[0];

  n8877_secbuf_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (idx),
    .wdata (mem_rdata),
    .raddr (faddr[7:1]),
    .rdata (ram_q)
  );

  // buf_valid is the registered tag_hit that qualified this RAM read.
  assign frdata = buf_valid ? ram_q : FILL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      frd_d     <= 1'b0;
      rd_miss   <= 1'b0;
    end else begin
      buf_valid <= tag_hit;
      frd_d     <= frd;
      rd_miss   <= frd && !frd_d && !tag_hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tag       <= '0;
      tag_valid <= 1'b0;
      fill_tag  <= '0;
      idx       <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!tag_hit) begin
            fill_tag  <= faddr[19:8];
            idx       <= '0;
            tag_valid <= 1'b0;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          mem_req  <= 1'b1;
          mem_addr <= word_addr;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // The request is held until acked; an abort is only honoured afterwards.
          if (mem_ack) begin
            mem_req <= 1'b0;
            idx     <= idx + 1'b1;
            if (idx == SEC_IDXW'(SEC_WORDS - 1)) begin
              state <= ST_DONE;
            end else if (faddr[19:8] != fill_tag) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_REQ;
            end
          end
        end
        ST_DONE: begin
          tag       <= fill_tag;
          tag_valid <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
